// File: rtl/jtframe_serjoy_reader.sv
// Serial joystick reader for a 74165-style adapter chain.
// Ports: rst/clk, enable; ser_load_n/ser_clk/ser_data chain lines;
//   board_joy1/board_joy2 (active-high), joy_valid, scan_done pulse.
module jtframe_serjoy_reader #(
  parameter int          CLKDIV      = 4,
  parameter int          JOY_BITS    = 12,
  parameter logic [15:0] SCAN_PERIOD = 16'd50000
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        enable,
  output logic        ser_load_n,
  output logic        ser_clk,
  input  logic        ser_data,
  output logic [15:0] board_joy1,
  output logic [15:0] board_joy2,
  output logic        joy_valid,
  output logic        scan_done
);

  localparam int RAW_W = 2 * JOY_BITS;

  localparam logic [RAW_W-1:0] ONES   = '1;
  localparam logic [RAW_W-1:0] ZEROS  = '0;
  localparam logic [15:0]      P_END  = SCAN_PERIOD - 16'd1;
  localparam logic [7:0]       HC_END = 8'(CLKDIV - 1);
  localparam logic [4:0]       LAST   = 5'(RAW_W - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [15:0]      cnt;
  logic             tick;
  logic [1:0]       sync;
  logic             sd;
  logic [2:0]       state;
  logic [2:0]       nstate;
  logic [7:0]       hc;
  logic [7:0]       nhc;
  logic [4:0]       idx;
  logic [4:0]       nidx;
  logic             sample;
  logic             abort;
  logic             hc_end;
  logic [RAW_W-1:0] raw;
  logic [RAW_W-1:0] prev;
  logic [15:0]      p1;
  logic [15:0]      p2;

  assign tick   = cnt == P_END;
  assign sd     = sync[1];
  assign hc_end = hc == HC_END;
  assign abort  = !enable && state != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sync <= 2'b11;
    end else begin
      cnt  <= tick ? 16'd0 : cnt + 16'd1;
      sync <= {sync[0], ser_data};
    end
  end

  // LOAD lasts two half periods; idx[0] marks the second one so the
  // half-period counter never has to count past CLKDIV.
  always_comb begin
    nstate = state;
    nhc    = hc;
    nidx   = idx;
    sample = 1'b0;
    if (!enable) begin
      nstate = IDLE;
      nhc    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            nstate = LOAD;
            nhc    = '0;
            nidx   = '0;
          end
        end
        LOAD: begin
          if (hc_end) begin
            nhc = '0;
            if (idx[0]) begin
              nstate = SHIFT_LO;
              nidx   = '0;
            end else begin
              nidx = 5'd1;
            end
          end else begin
            nhc = hc + 8'd1;
          end
        end
        SHIFT_LO: begin
          if (hc_end) begin
            sample = 1'b1;
            nstate = SHIFT_HI;
            nhc    = '0;
          end else begin
            nhc = hc + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (hc_end) begin
            nhc = '0;
            if (idx == LAST) begin
              nstate = DONE;
            end else begin
              nidx   = idx + 5'd1;
              nstate = SHIFT_LO;
            end
          end else begin
            nhc = hc + 8'd1;
          end
        end
        DONE:    nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    p1 = '0;
    p2 = '0;
    p1[JOY_BITS-1:0] = ~raw[JOY_BITS-1:0];
    p2[JOY_BITS-1:0] = ~raw[RAW_W-1:JOY_BITS];
  end

  // Chain lines are registered copies of the next state so the
  // adapter never sees decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hc         <= '0;
      idx        <= '0;
      raw        <= ONES;
      prev       <= ONES;
      ser_load_n <= 1'b1;
      ser_clk    <= 1'b0;
      scan_done  <= 1'b0;
      board_joy1 <= '0;
      board_joy2 <= '0;
      joy_valid  <= 1'b0;
    end else begin
      state      <= nstate;
      hc         <= nhc;
      idx        <= nidx;
      ser_load_n <= nstate != LOAD;
      ser_clk    <= nstate == SHIFT_HI;
      scan_done  <= nstate == DONE;
      if (sample) begin
        for (int i = 0; i < RAW_W; i++) begin
          if (idx == 5'(i)) raw[i] <= sd;
        end
      end
      if (abort) begin
        prev <= ONES;
      end else if (state == DONE) begin
        prev <= raw;
        // All-zero means a floating line: no adapter present.
        if (raw == prev) begin
          if (raw == ZEROS) begin
            board_joy1 <= '0;
            board_joy2 <= '0;
            joy_valid  <= 1'b0;
          end else begin
            board_joy1 <= p1;
            board_joy2 <= p2;
            joy_valid  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_serjoy_reader.sv
// Bench for jtframe_serjoy_reader: chain model plus scoreboard
// checking joystick outputs after every completed scan.
module tb_jtframe_serjoy_reader;

  localparam logic [15:0] SP = 16'd1000;

  logic        rst;
  logic        clk = 1'b0;
  logic        enable;
  logic        ser_load_n;
  logic        ser_clk;
  logic        ser_data;
  logic [15:0] board_joy1;
  logic [15:0] board_joy2;
  logic        joy_valid;
  logic        scan_done;

  always #5 clk = ~clk;

  jtframe_serjoy_reader #(
    .CLKDIV      (4),
    .JOY_BITS    (12),
    .SCAN_PERIOD (SP)
  ) dut (
    .rst        (rst),
    .clk        (clk),
    .enable     (enable),
    .ser_load_n (ser_load_n),
    .ser_clk    (ser_clk),
    .ser_data   (ser_data),
    .board_joy1 (board_joy1),
    .board_joy2 (board_joy2),
    .joy_valid  (joy_valid),
    .scan_done  (scan_done)
  );

  logic [23:0] pat;
  logic [23:0] shreg;
  logic        sclk_d;

  always @(posedge clk) begin
    if (rst) begin
      shreg  <= '1;
      sclk_d <= 1'b0;
    end else begin
      sclk_d <= ser_clk;
      if (!ser_load_n) shreg <= pat;
      else if (ser_clk && !sclk_d) shreg <= {1'b0, shreg[23:1]};
    end
  end

  assign ser_data = shreg[0];

  typedef struct packed {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        v;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (scan_done) begin
        @(negedge clk);
        chk("done_pulse", 32'(scan_done), 32'd0);
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          me = q.pop_front();
          chk("joy1", 32'(board_joy1), 32'(me.j1));
          chk("joy2", 32'(board_joy2), 32'(me.j2));
          chk("valid", 32'(joy_valid), 32'(me.v));
        end
      end
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (scan_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("scan_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_load();
    int n;
    n = 0;
    while (ser_load_n && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("load_seen", 32'(ser_load_n), 32'd0);
  endtask

  task automatic push(input logic [15:0] e1, input logic [15:0] e2,
                      input logic ev);
    exp_t e;
    e.j1 = e1;
    e.j2 = e2;
    e.v  = ev;
    q.push_back(e);
  endtask

  task automatic run_scan(input logic [23:0] p, input logic [15:0] e1,
                          input logic [15:0] e2, input logic ev);
    pat = p;
    push(e1, e2, ev);
    wait_done();
    repeat (2) @(negedge clk);
  endtask

  task automatic measure_scan();
    int  n;
    int  lo;
    int  hi;
    int  pu;
    logic pc;
    pat = '1;
    push(16'h0000, 16'h0000, 1'b1);
    wait_load();
    n  = 0;
    lo = 0;
    hi = 0;
    pu = 0;
    pc = 1'b0;
    while (n < 400) begin
      n++;
      if (!ser_load_n) lo++;
      if (ser_clk) hi++;
      if (ser_clk && !pc) pu++;
      pc = ser_clk;
      if (scan_done) break;
      @(negedge clk);
    end
    chk("load_len", 32'(lo), 32'd8);
    chk("clk_hi_cycles", 32'(hi), 32'd96);
    chk("clk_pulses", 32'(pu), 32'd24);
    chk("scan_len", 32'(n), 32'd201);
    repeat (2) @(negedge clk);
  endtask

  task automatic abort_scan();
    int  pu;
    int  nd;
    logic pc;
    pat = 24'hFFFFFD;
    wait_load();
    pu = 0;
    pc = 1'b0;
    for (int i = 0; i < 400 && pu < 11; i++) begin
      @(negedge clk);
      if (ser_clk && !pc) pu++;
      pc = ser_clk;
    end
    chk("abort_pulses", 32'(pu), 32'd11);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_sclk", 32'(ser_clk), 32'd0);
    chk("abort_load", 32'(ser_load_n), 32'd1);
    nd = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (scan_done) nd++;
    end
    chk("abort_nodone", 32'(nd), 32'd0);
    chk("abort_hold1", 32'(board_joy1), 32'h0000);
    chk("abort_holdv", 32'(joy_valid), 32'd1);
    enable = 1'b1;
  endtask

  task automatic reset_mid_scan();
    int n;
    pat = 24'hFFFFFD;
    wait_load();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_joy1", 32'(board_joy1), 32'h0000);
    chk("rst_valid", 32'(joy_valid), 32'd0);
    chk("rst_load", 32'(ser_load_n), 32'd1);
    chk("rst_sclk", 32'(ser_clk), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(16'h0000, 16'h0000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ser_load_n && n < 3000);
    chk("tick_after_rst", 32'(n), 32'(SP));
    wait_done();
    repeat (2) @(negedge clk);
    run_scan(24'hFFFFFD, 16'h0002, 16'h0000, 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    pat    = '1;
    repeat (3) @(negedge clk);
    chk("init_joy1", 32'(board_joy1), 32'h0000);
    chk("init_joy2", 32'(board_joy2), 32'h0000);
    chk("init_valid", 32'(joy_valid), 32'd0);
    chk("init_load", 32'(ser_load_n), 32'd1);
    chk("init_sclk", 32'(ser_clk), 32'd0);
    chk("init_done", 32'(scan_done), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;

    measure_scan();
    run_scan(24'hFFFFFF, 16'h0000, 16'h0000, 1'b1);
    run_scan(24'hFF7FEE, 16'h0000, 16'h0000, 1'b1);
    run_scan(24'hFF7FEE, 16'h0011, 16'h0008, 1'b1);
    run_scan(24'hFFFFFD, 16'h0011, 16'h0008, 1'b1);
    run_scan(24'hFFFFFB, 16'h0011, 16'h0008, 1'b1);
    run_scan(24'hFFFFFD, 16'h0011, 16'h0008, 1'b1);
    run_scan(24'hFFFFFB, 16'h0011, 16'h0008, 1'b1);
    run_scan(24'h000000, 16'h0011, 16'h0008, 1'b1);
    run_scan(24'h000000, 16'h0000, 16'h0000, 1'b0);
    run_scan(24'hFFFFFF, 16'h0000, 16'h0000, 1'b0);
    run_scan(24'hFFFFFF, 16'h0000, 16'h0000, 1'b1);
    run_scan(24'hFFFFFD, 16'h0000, 16'h0000, 1'b1);

    abort_scan();
    run_scan(24'hFFFFFD, 16'h0000, 16'h0000, 1'b1);
    run_scan(24'hFFFFFD, 16'h0002, 16'h0000, 1'b1);

    reset_mid_scan();

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
